// File: rtl/polybus_axil_pkg.sv
// rtl/polybus_axil_pkg.sv - shared types and AXI4-Lite constants for the PolyBUS arbiter
package polybus_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WRESP,
    ST_RD,
    ST_RDATA,
    ST_DONE
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/polybus_axil_arbiter_if.sv
// rtl/polybus_axil_arbiter_if.sv - AXI4-Lite bus between the arbiter (master) and the register bank (slave)
interface polybus_axil_arbiter_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/polybus_rr_arbiter.sv
// rtl/polybus_rr_arbiter.sv - combinational round-robin pick starting one past last_grant
module polybus_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    grant_idx,
  output logic               grant_any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/polybus_axil_arbiter.sv
// rtl/polybus_axil_arbiter.sv - round-robin arbiter sharing one AXI4-Lite slave among NUM_REQ requesters
// Optional watchdog on stalled AXI phases: POLYBUS_ARB_TIMEOUT_EN
module polybus_axil_arbiter
  import polybus_axil_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
`ifdef POLYBUS_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*4-1:0]           req_wstrb,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]          resp_rdata,
  output logic [1:0]                     resp_resp,
  polybus_axil_arbiter_if.master         m_axi
);

  localparam int IDXW = $clog2(NUM_REQ);

  arb_state_t            state_q, state_d;
  logic [IDXW-1:0]       last_grant_q, last_grant_d;
  logic [IDXW-1:0]       gidx_q, gidx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
`ifdef POLYBUS_ARB_TIMEOUT_EN
  logic [15:0]           tmo_q, tmo_d;
`endif

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDXW-1:0]    arb_idx;
  logic               arb_any;

  polybus_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_any  (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gidx_d       = gidx_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    req_ready    = '0;

    case (state_q)
      ST_IDLE: begin
        // ARESET gating keeps req_ready at 0 while reset is held, like every other output
        if (arb_any && !ARESET) begin
          req_ready    = arb_grant;
          last_grant_d = arb_idx;
          gidx_d       = arb_idx;
          addr_d       = req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH] & ~ADDR_WIDTH'(3);
          wdata_d      = req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
          wstrb_d      = req_wstrb[int'(arb_idx)*4 +: 4];
          rdata_d      = '0;
          resp_d       = AXI_RESP_OKAY;
          state_d      = req_write[arb_idx] ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        aw_done_d = aw_done_q | m_axi.awready;
        w_done_d  = w_done_q | m_axi.wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (m_axi.bvalid) begin
          resp_d  = m_axi.bresp;
          state_d = ST_DONE;
        end
      end
      ST_RD: begin
        if (m_axi.arready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (m_axi.rvalid) begin
          rdata_d = m_axi.rdata;
          resp_d  = m_axi.rresp;
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

`ifdef POLYBUS_ARB_TIMEOUT_EN
    tmo_d = '0;
    if (state_q inside {ST_WR, ST_WRESP, ST_RD, ST_RDATA} && state_d == state_q) begin
      tmo_d = tmo_q + 16'd1;
      // abandon the slave: valids/readies fall because they decode from state
      if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
        tmo_d     = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        rdata_d   = '0;
        resp_d    = AXI_RESP_SLVERR;
        state_d   = ST_DONE;
      end
    end
`endif
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDXW'(NUM_REQ - 1);
      gidx_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rdata_q      <= '0;
      resp_q       <= '0;
`ifdef POLYBUS_ARB_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gidx_q       <= gidx_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
`ifdef POLYBUS_ARB_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = AXI_PROT_DEFAULT;
  assign m_axi.awvalid = (state_q == ST_WR) && !aw_done_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = (state_q == ST_WR) && !w_done_q;
  assign m_axi.bready  = (state_q == ST_WRESP);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = AXI_PROT_DEFAULT;
  assign m_axi.arvalid = (state_q == ST_RD);
  assign m_axi.rready  = (state_q == ST_RDATA);

  assign resp_rdata = (state_q == ST_DONE) ? rdata_q : '0;
  assign resp_resp  = (state_q == ST_DONE) ? resp_q  : '0;

  always_comb begin
    resp_valid = '0;
    if (state_q == ST_DONE) resp_valid[gidx_q] = 1'b1;
  end

endmodule

// File: tb/tb_polybus_axil_arbiter.sv
// tb/tb_polybus_axil_arbiter.sv - directed bench with a transaction-timing model and reactive AXI4-Lite slave
module tb_polybus_axil_arbiter;

  localparam int NREQ = 2;
  localparam int TMO  = 16;

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        lit_en;
    logic [31:0] lit_rdata;
    logic [1:0]  lit_resp;
  } cmd_t;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [NREQ-1:0]    req_valid, req_ready, req_write, resp_valid;
  logic [NREQ*4-1:0]  req_addr, req_wstrb;
  logic [NREQ*32-1:0] req_wdata;
  logic [31:0]        resp_rdata;
  logic [1:0]         resp_resp;

  polybus_axil_arbiter_if #(.ADDR_WIDTH(4)) bus ();

  polybus_axil_arbiter #(
    .NUM_REQ(NREQ), .ADDR_WIDTH(4), .DATA_WIDTH(32)
`ifdef POLYBUS_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .ACLK(aclk), .ARESET(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_resp(resp_resp),
    .m_axi(bus)
  );

  // slave environment
  logic [31:0] s_mem [4];
  int          s_wcnt, s_wdelay, s_bcnt, s_bdelay;
  logic        s_aw_got, s_w_got, s_bpend, s_bvalid, s_rvalid, s_ar_block;
  logic [3:0]  s_aw_a;
  logic [31:0] s_w_d, s_rdata;
  logic [3:0]  s_w_s;
  logic [1:0]  s_bresp;

  assign bus.awready = 1'b1;
  assign bus.wready  = (s_wcnt >= s_wdelay);
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;
  assign bus.arready = !s_ar_block;
  assign bus.rvalid  = s_rvalid;
  assign bus.rdata   = s_rdata;
  assign bus.rresp   = 2'b00;

  // requester queues and expected-behaviour model
  cmd_t        cq [NREQ][$];
  logic [31:0] mem_m [4];
  int          cyc, n_chk, n_pass, n_resp_obs;
  logic        m_busy;
  int          m_t, m_resp_at, m_req, m_last, m_wd, m_bd;
  logic        m_blk;
  cmd_t        m_cmd;
  logic [31:0] m_rdata;
  logic [1:0]  m_resp;
  logic [NREQ-1:0] obs_grants [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(int r, logic w, logic [3:0] a, logic [31:0] d, logic [3:0] s,
                      logic le, logic [31:0] lr, logic [1:0] lp);
    cmd_t c;
    c.w = w; c.a = a; c.d = d; c.s = s; c.lit_en = le; c.lit_rdata = lr; c.lit_resp = lp;
    cq[r].push_back(c);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (cq[i].size() != 0) begin
        req_valid[i]         = 1'b1;
        req_write[i]         = cq[i][0].w;
        req_addr[i*4 +: 4]   = cq[i][0].a;
        req_wdata[i*32 +: 32] = cq[i][0].d;
        req_wstrb[i*4 +: 4]  = cq[i][0].s;
      end else begin
        req_valid[i]         = 1'b0;
        req_write[i]         = 1'b0;
        req_addr[i*4 +: 4]   = '0;
        req_wdata[i*32 +: 32] = '0;
        req_wstrb[i*4 +: 4]  = '0;
      end
    end
  endtask

  task automatic model_start(int g);
    m_busy = 1'b1; m_t = cyc; m_req = g; m_cmd = cq[g][0]; m_last = g;
    m_wd = s_wdelay; m_bd = s_bdelay; m_blk = s_ar_block;
    if (m_cmd.w) begin
      m_rdata = 0; m_resp = s_bresp; m_resp_at = cyc + 3 + m_wd + m_bd;
      for (int b = 0; b < 4; b++)
        if (m_cmd.s[b]) mem_m[m_cmd.a[3:2]][8*b +: 8] = m_cmd.d[8*b +: 8];
    end else if (m_blk) begin
      m_rdata = 0; m_resp = 2'b10; m_resp_at = cyc + 1 + TMO;
    end else begin
      m_rdata = mem_m[m_cmd.a[3:2]]; m_resp = 2'b00; m_resp_at = cyc + 3;
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] erdy, erv, rdy_seen;
    logic eaw, ew, eb, ear, er, aw_f, w_f, b_f, ar_f, r_f, wv;
    logic [3:0] aw_a, ar_a;
    logic [31:0] w_d;
    logic [3:0] w_s;
    int k, g;
    @(negedge aclk);
    if (m_busy && cyc > m_resp_at) m_busy = 1'b0;
    erdy = '0; erv = '0;
    if (!m_busy && req_valid != 0) begin
      g = -1;
      for (int j = 1; j <= NREQ; j++) begin
        int i = (m_last + j) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
      erdy[g] = 1'b1;
      model_start(g);
    end
    {eaw, ew, eb, ear, er} = '0;
    if (m_busy) begin
      k = cyc - m_t;
      if (m_cmd.w) begin
        eaw = (k == 1);
        ew  = (k >= 1 && k <= 1 + m_wd);
        eb  = (k >= 2 + m_wd && k <= 2 + m_wd + m_bd);
      end else if (m_blk) begin
        ear = (k >= 1 && k <= TMO);
      end else begin
        ear = (k == 1);
        er  = (k == 2);
      end
      if (cyc == m_resp_at) erv[m_req] = 1'b1;
    end
    chk("req_ready", req_ready, erdy);
    chk("resp_valid", resp_valid, erv);
    chk("awvalid", bus.awvalid, eaw);
    chk("wvalid", bus.wvalid, ew);
    chk("bready", bus.bready, eb);
    chk("arvalid", bus.arvalid, ear);
    chk("rready", bus.rready, er);
    if (eaw) chk("awaddr", {bus.awprot, bus.awaddr}, {3'b000, m_cmd.a & 4'hC});
    if (ew)  chk("wdata", {bus.wstrb, bus.wdata}, {m_cmd.s, m_cmd.d});
    if (ear) chk("araddr", {bus.arprot, bus.araddr}, {3'b000, m_cmd.a & 4'hC});
    if (erv != 0) begin
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_resp", resp_resp, m_resp);
      if (m_cmd.lit_en) begin
        chk("lit_rdata", resp_rdata, m_cmd.lit_rdata);
        chk("lit_resp", resp_resp, m_cmd.lit_resp);
      end
    end
    aw_f = bus.awvalid && bus.awready; aw_a = bus.awaddr;
    w_f  = bus.wvalid && bus.wready;   w_d = bus.wdata; w_s = bus.wstrb; wv = bus.wvalid;
    b_f  = bus.bvalid && bus.bready;
    ar_f = bus.arvalid && bus.arready; ar_a = bus.araddr;
    r_f  = bus.rvalid && bus.rready;
    rdy_seen = req_ready;
    if (rdy_seen != 0) obs_grants.push_back(rdy_seen);
    if (resp_valid != 0) n_resp_obs++;
    @(posedge aclk);
    #1;
    cyc++;
    if (b_f) s_bvalid = 1'b0;
    if (r_f) s_rvalid = 1'b0;
    if (aw_f) begin s_aw_got = 1'b1; s_aw_a = aw_a; end
    if (w_f) begin s_w_got = 1'b1; s_w_d = w_d; s_w_s = w_s; s_wcnt = 0; end
    else if (wv) s_wcnt++;
    if (s_aw_got && s_w_got) begin
      for (int b = 0; b < 4; b++)
        if (s_w_s[b]) s_mem[s_aw_a[3:2]][8*b +: 8] = s_w_d[8*b +: 8];
      s_aw_got = 1'b0; s_w_got = 1'b0; s_bpend = 1'b1; s_bcnt = s_bdelay;
    end
    if (s_bpend) begin
      if (s_bcnt == 0) begin s_bvalid = 1'b1; s_bpend = 1'b0; end
      else s_bcnt--;
    end
    if (ar_f) begin s_rdata = s_mem[ar_a[3:2]]; s_rvalid = 1'b1; end
    for (int i = 0; i < NREQ; i++)
      if (rdy_seen[i] && cq[i].size() != 0) void'(cq[i].pop_front());
    drive();
  endtask

  task automatic run_idle(int budget);
    int n = 0;
    while ((cq[0].size() != 0 || cq[1].size() != 0 || m_busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_budget", 1, 0);
  endtask

  task automatic slave_clear();
    s_wcnt = 0; s_aw_got = 0; s_w_got = 0; s_bpend = 0; s_bcnt = 0;
    s_bvalid = 0; s_rvalid = 0; s_rdata = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; n_resp_obs = 0;
    m_busy = 0; m_last = NREQ - 1;
    s_wdelay = 0; s_bdelay = 0; s_ar_block = 0; s_bresp = 2'b00;
    slave_clear();
    for (int i = 0; i < 4; i++) begin s_mem[i] = 0; mem_m[i] = 0; end
    drive();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_axi_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    chk("rst_resp", {resp_rdata, resp_resp}, 0);
    areset = 1'b0;

    // contention: both requesters assert continuously
    for (int i = 0; i < 4; i++) begin
      push(0, 1, 4'h0, 32'h10 + i, 4'hF, 0, 0, 0);
      push(1, 1, 4'h4, 32'h20 + i, 4'hF, 0, 0, 0);
    end
    push(0, 0, 4'h0, 0, 0, 1, 32'h13, 2'b00);
    push(1, 0, 4'h4, 0, 0, 1, 32'h23, 2'b00);
    obs_grants.delete();
    drive();
    run_idle(200);
    chk("cont_ngrants", obs_grants.size(), 10);
    for (int i = 0; i < 10 && i < obs_grants.size(); i++)
      chk("cont_order", obs_grants[i], (i % 2 == 0) ? 2'b01 : 2'b10);

    // write/read sweep on requester 0
    n_resp_obs = 0;
    for (int i = 0; i < 4; i++) push(0, 1, 4'(4 * i), 32'(i + 1), 4'hF, 1, 0, 2'b00);
    drive();
    run_idle(200);
    chk("sweep_wr_pulses", n_resp_obs, 4);
    n_resp_obs = 0;
    for (int i = 0; i < 4; i++) push(0, 0, 4'(4 * i), 0, 0, 1, 32'(i + 1), 2'b00);
    drive();
    run_idle(200);
    chk("sweep_rd_pulses", n_resp_obs, 4);

    // backpressure on W, partial strobe, unaligned address
    n_resp_obs = 0;
    s_wdelay = 3;
    push(0, 1, 4'hA, 32'hDEADBEEF, 4'b0011, 1, 0, 2'b00);
    drive();
    run_idle(200);
    chk("bp_pulses", n_resp_obs, 1);
    s_wdelay = 0;
    push(1, 0, 4'h8, 0, 0, 1, 32'h0000BEEF, 2'b00);
    drive();
    run_idle(200);

    // error response is forwarded, next transaction normal
    s_bresp = 2'b10;
    push(1, 1, 4'hC, 32'h55, 4'hF, 1, 0, 2'b10);
    drive();
    run_idle(200);
    s_bresp = 2'b00;
    push(0, 0, 4'hC, 0, 0, 1, 32'h55, 2'b00);
    drive();
    run_idle(200);

    // reset during WRESP
    s_bdelay = 5;
    push(0, 1, 4'h0, 32'h77, 4'hF, 0, 0, 0);
    drive();
    begin
      int n = 0;
      while (!(m_busy && cyc - m_t == 3) && n < 50) begin step(); n++; end
      if (n >= 50) chk("reach_wresp", 0, 1);
    end
    chk("pre_rst_bready", bus.bready, 1);
    #2;
    areset = 1'b1;
    #1;
    chk("mid_rst_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    chk("mid_rst_resp", resp_valid, 0);
    m_busy = 0; m_last = NREQ - 1; s_bdelay = 0;
    slave_clear();
    repeat (2) begin @(posedge aclk); #1; cyc++; end
    areset = 1'b0;
    n_resp_obs = 0;
    obs_grants.delete();
    push(1, 0, 4'h0, 0, 0, 1, 32'h77, 2'b00);
    drive();
    run_idle(100);
    chk("post_rst_grant", (obs_grants.size() > 0) ? obs_grants[0] : 2'b00, 2'b10);
    chk("post_rst_pulses", n_resp_obs, 1);

`ifdef POLYBUS_ARB_TIMEOUT_EN
    s_ar_block = 1;
    push(0, 0, 4'h4, 0, 0, 1, 32'h0, 2'b10);
    drive();
    run_idle(100);
    s_ar_block = 0;
    push(0, 0, 4'h4, 0, 0, 1, 32'h2, 2'b00);
    drive();
    run_idle(100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/polybus_axil_arbiter.md
Name: polybus_axil_arbiter

Overview:
- Shares one AXI4-Lite slave port (the PolyBUSip register bank, 4 x 32-bit registers) among NUM_REQ on-chip requesters.
- Each requester issues single-word read/write commands over a simple valid/ready interface.
- The block arbitrates round-robin, runs the AXI4-Lite handshake as master, and returns a one-cycle response pulse to the granted requester.
- Only one transaction is outstanding at a time.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 4, AXI4-Lite byte address width; word-aligned.
- DATA_WIDTH, 32, data width; fixed at 32.
- TIMEOUT_CYCLES, 255, watchdog limit, used only with POLYBUS_ARB_TIMEOUT_EN.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  command valid per requester.
- req_ready  out  NUM_REQ  one-hot, one-cycle command accept.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*32  packed write data.
- req_wstrb  in  NUM_REQ*4  packed byte strobes.
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- resp_rdata  out  32  read data; valid with resp_valid.
- resp_resp  out  2  BRESP or RRESP of the completed transaction.
- M_AXI_AWADDR, M_AXI_AWPROT(3), M_AXI_AWVALID  out  AXI write-address channel.
- M_AXI_AWREADY  in  1.
- M_AXI_WDATA(32), M_AXI_WSTRB(4), M_AXI_WVALID  out  AXI write-data channel.
- M_AXI_WREADY  in  1.
- M_AXI_BRESP(2), M_AXI_BVALID  in.
- M_AXI_BREADY  out  1.
- M_AXI_ARADDR, M_AXI_ARPROT(3), M_AXI_ARVALID  out  AXI read-address channel.
- M_AXI_ARREADY  in  1.
- M_AXI_RDATA(32), M_AXI_RRESP(2), M_AXI_RVALID  in.
- M_AXI_RREADY  out  1.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
- AxPROT is constant 3'b000.
- FSM states: IDLE, WR, WRESP, RD, RDATA, DONE.
- IDLE: if any req_valid, pick the first set requester starting at last_grant+1 (modulo NUM_REQ).
  - Pulse req_ready[g] for one cycle.
  - Capture addr (bits [1:0] forced 0), wdata, wstrb, write.
  - Update last_grant = g.
  - Next state WR or RD.
- WR: AWVALID and WVALID both assert the cycle after accept.
  - Each drops independently on its own ready.
  - Go to WRESP once both handshakes are done (same cycle or different cycles).
- WRESP: BREADY = 1. On BVALID, capture BRESP and go to DONE.
- RD: ARVALID = 1 until ARREADY, then RDATA.
- RDATA: RREADY = 1. On RVALID, capture RDATA/RRESP and go to DONE.
- DONE: resp_valid[g] = 1 for exactly one cycle with resp_rdata/resp_resp, then IDLE.
  - resp_rdata is 0 for writes.
- Latency with a zero-wait slave (ready already high, response next cycle):
  - Write: accept at cycle N, AW/W at N+1, B at N+2, resp_valid at N+3.
  - Read: same timing.
  - New accept no earlier than N+4.
- Requester rules: a requester must hold req_* stable until req_ready. Dropping req_valid before grant is legal; no grant is issued.
- No starvation: with all requesters asserting continuously, grants rotate 0, 1, ..., NUM_REQ-1, 0.
- BRESP/RRESP SLVERR or DECERR is forwarded unchanged; no retry.
- Any AXI input other than the one expected in the current state is ignored.
- ARESET mid-transaction: outputs drop to 0 asynchronously and state returns to IDLE. The in-flight transaction gets no resp_valid.

Optional Feature:
- Macro: POLYBUS_ARB_TIMEOUT_EN.
- Defined: an 8-bit+ counter runs in WR, WRESP, RD and RDATA, and clears on every state change.
  - On reaching TIMEOUT_CYCLES: drop all AXI valids/readies and go to DONE with resp_resp = 2'b10 (SLVERR) and resp_rdata = 0.
  - A late BVALID/RVALID after timeout is ignored in IDLE.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Package polybus_axil_pkg:
  - State enum arb_state_t.
  - Constants AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11.
  - AXI_PROT_DEFAULT = 3'b000.
- Sub-module polybus_rr_arbiter: combinational round-robin pick from req vector and last_grant pointer; outputs one-hot grant and index.

Test Plan:
- Write/read sweep: req0 writes 0x1, 0x2, 0x3, 0x4 to addrs 0x0, 0x4, 0x8, 0xC, then reads back -> each resp_rdata matches, resp_resp = 0, four resp_valid pulses per phase.
- Contention: req0 and req1 both assert continuously (writes to 0x0 / 0x4) -> req_ready order 0, 1, 0, 1; no double grant; final reads return the last values written.
- Backpressure: slave holds WREADY low 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID stays high until WREADY, single B, one resp_valid.
- Error response: slave returns BRESP = 2'b10 -> resp_resp = 2'b10 on the requester's resp_valid; next request proceeds normally.
- Reset mid-operation: ARESET asserted during WRESP -> all AXI valids/readies 0 immediately, no resp_valid; after release req1 alone is granted first.
- Timeout (POLYBUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16): slave never asserts ARREADY -> resp_valid 16 cycles into RD with resp_resp = 2'b10 and resp_rdata = 0.
